// File: rtl/rv32_reg_file_pkg.sv
// Core-wide register file constants and types, shared by the decode and
// write-back stages.
//   XLEN       : integer register width
//   REG_ADDR_W : register address width
//   NUM_REGS   : architectural register count
//   REG_ZERO   : index of the hardwired-zero register (x0)
package rv32_reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int REG_ZERO   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/rv32_reg_file_read_port.sv
// rf_read_port: one combinational register-file read port.
// Selects an entry from the flattened storage array and forces x0 to zero.
// Build option RF_BYPASS_EN: adds write-through forwarding, so a
// same-cycle write to the addressed register is returned directly.
// Ports:
//   addr     : read address
//   regs     : all storage entries, packed
//   wr_en    : write enable        (RF_BYPASS_EN only)
//   wr_addr  : write address       (RF_BYPASS_EN only)
//   wr_data  : write data          (RF_BYPASS_EN only)
//   data     : read data
module rf_read_port
    import rv32_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0]                        addr,
    input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]   regs,
`ifdef RF_BYPASS_EN
    input  logic                                         wr_en,
    input  logic [ADDR_WIDTH-1:0]                        wr_addr,
    input  logic [DATA_WIDTH-1:0]                        wr_data,
`endif
    output logic [DATA_WIDTH-1:0]                        data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    always_comb begin
        data = regs[addr];
`ifdef RF_BYPASS_EN
        // Forward the write-back value in the same cycle it is being written.
        if (wr_en && (wr_addr != ZERO_ADDR) && (wr_addr == addr))
            data = wr_data;
`endif
        // x0 reads zero in every case, forwarding included.
        if (addr == ZERO_ADDR)
            data = '0;
    end

endmodule

// File: rtl/rv32_reg_file.sv
// rv32_reg_file: RV32I integer register file for the decode stage.
// Two combinational read ports (rs1, rs2), one synchronous write port (WB).
// x0 is never written and always reads zero. Synchronous active-low reset
// clears every entry and takes priority over a write in the same cycle.
// Build option RF_BYPASS_EN: same-cycle write-through forwarding to reads.
// Ports:
//   clk             : clock, rising edge
//   reset_n         : synchronous active-low reset
//   reg1_addr_i     : rs1 address        data1_o : rs1 data
//   reg2_addr_i     : rs2 address        data2_o : rs2 data
//   writereg_addr_i : rd address from WB
//   data_i          : write data
//   data_write_i    : write enable
module rv32_reg_file
    import rv32_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] reg1_addr_i,
    input  logic [ADDR_WIDTH-1:0] reg2_addr_i,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic [DATA_WIDTH-1:0] data2_o,
    input  logic [ADDR_WIDTH-1:0] writereg_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_write_i
);

    localparam int NUM_ENTRIES  = 2 ** ADDR_WIDTH;
    localparam int NUM_RD_PORTS = 2;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0]  regs;
    logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

    // Entry 0 is only ever loaded by reset, so it holds zero; the read
    // ports zero x0 as well so the value never depends on it.
    always_ff @(posedge clk) begin
        if (!reset_n)
            regs <= '0;
        else if (data_write_i && (writereg_addr_i != ZERO_ADDR))
            regs[writereg_addr_i] <= data_i;
    end

    assign rd_addr = {reg2_addr_i, reg1_addr_i};

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        rf_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_rd (
            .addr    (rd_addr[p]),
            .regs    (regs),
`ifdef RF_BYPASS_EN
            .wr_en   (data_write_i),
            .wr_addr (writereg_addr_i),
            .wr_data (data_i),
`endif
            .data    (rd_data[p])
        );
    end

    assign data1_o = rd_data[0];
    assign data2_o = rd_data[1];

endmodule

// File: tb/tb_rv32_reg_file.sv
module tb_rv32_reg_file;
    import rv32_reg_file_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic      clk;
    logic      reset_n;
    reg_addr_t ra1, ra2, wa;
    xlen_t     d1, d2, wd;
    logic      we;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of architectural register values.
    xlen_t mem [NUM_REGS];

    rv32_reg_file dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .reg1_addr_i     (ra1),
        .reg2_addr_i     (ra2),
        .data1_o         (d1),
        .data2_o         (d2),
        .writereg_addr_i (wa),
        .data_i          (wd),
        .data_write_i    (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      rst_n;
        logic      we;
        reg_addr_t wa;
        xlen_t     wd;
        reg_addr_t a1;
        reg_addr_t a2;
        xlen_t     e1;
        xlen_t     e2;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input xlen_t act, input xlen_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Value a read port should show right now, from architectural rules.
    function automatic xlen_t model_rd(input reg_addr_t a);
        if (a == 0) return '0;
        if (BYP && reset_n !== 1'bx && we && wa != 0 && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic drive(input logic r, input logic w, input reg_addr_t wadr,
                         input xlen_t wdat, input reg_addr_t a1, input reg_addr_t a2);
        reset_n = r; we = w; wa = wadr; wd = wdat; ra1 = a1; ra2 = a2;
    endtask

    // Advance through the rising edge and apply the same update to the model.
    task automatic edge_update();
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        end else if (we && wa != 0) begin
            mem[wa] = wd;
        end
        #1;
    endtask

    function automatic xlen_t fill_val(input int r);
        return 32'hA500_0000 ^ (r * 32'h0101_0137);
    endfunction

    initial begin
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        @(negedge clk);
        edge_update();

        // Reset state: every address reads zero on both ports.
        for (int a = 0; a < NUM_REGS; a++) begin
            drive(1'b1, 1'b0, '0, '0, reg_addr_t'(a), reg_addr_t'(NUM_REGS - 1 - a));
            #1;
            chk($sformatf("reset_p1_x%0d", a), d1, '0);
            chk($sformatf("reset_p2_x%0d", NUM_REGS - 1 - a), d2, '0);
        end

        // Directed vectors; expectations are what the ports show before
        // the edge that ends the row.
        tbl[0]  = '{1, 1, 5,  32'hDEADBEEF, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,  32'h0,        5, 5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2]  = '{1, 1, 0,  32'h12345678, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0,  32'h0,        0, 0, 0, 0};
        tbl[4]  = '{1, 0, 7,  32'hFFFFFFFF, 7, 5, 0, 32'hDEADBEEF};
        tbl[5]  = '{1, 0, 0,  32'h0,        7, 0, 0, 0};
        tbl[6]  = '{1, 1, 10, 32'h1,        0, 5, 0, 32'hDEADBEEF};
        tbl[7]  = '{1, 1, 10, 32'h2,        10, 10, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1};
        tbl[8]  = '{1, 0, 0,  32'h0,        10, 0, 32'h2, 0};
        tbl[9]  = '{0, 1, 3,  32'hAA,       3, 5, BYP ? 32'hAA : 32'h0, 32'hDEADBEEF};
        tbl[10] = '{1, 0, 0,  32'h0,        3, 5, 0, 0};
        tbl[11] = '{1, 0, 0,  32'h0,        10, 7, 0, 0};

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst_n, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2);
            @(negedge clk);
            chk($sformatf("vec%0d_p1", i), d1, tbl[i].e1);
            chk($sformatf("vec%0d_p2", i), d2, tbl[i].e2);
            edge_update();
        end

        // Fill x1..x31 with distinct values, read each back, then reset.
        for (int r = 1; r < NUM_REGS; r++) begin
            drive(1'b1, 1'b1, reg_addr_t'(r), fill_val(r), '0, '0);
            edge_update();
        end
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        for (int r = 0; r < NUM_REGS; r++) begin
            ra1 = reg_addr_t'(r);
            ra2 = reg_addr_t'(NUM_REGS - 1 - r);
            #1;
            chk($sformatf("fill_p1_x%0d", r), d1, (r == 0) ? '0 : fill_val(r));
            chk($sformatf("fill_p2_x%0d", NUM_REGS - 1 - r), d2,
                (r == NUM_REGS - 1) ? '0 : fill_val(NUM_REGS - 1 - r));
        end
        drive(1'b0, 1'b0, '0, '0, '0, '0);
        edge_update();
        drive(1'b1, 1'b0, '0, '0, '0, '0);
        for (int r = 0; r < NUM_REGS; r++) begin
            ra1 = reg_addr_t'(r);
            ra2 = reg_addr_t'(r);
            #1;
            chk($sformatf("rst2_p1_x%0d", r), d1, '0);
            chk($sformatf("rst2_p2_x%0d", r), d2, '0);
        end

        // Random traffic against the model, with occasional resets and
        // frequent read-the-write-target collisions.
        for (int i = 0; i < 600; i++) begin
            logic      r, w;
            reg_addr_t a, b, c;
            r = ($urandom_range(0, 39) != 0);
            w = $urandom_range(0, 3) != 0;
            c = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            a = ($urandom_range(0, 3) == 0) ? c : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            b = ($urandom_range(0, 3) == 0) ? c : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            drive(r, w, c, xlen_t'($urandom), a, b);
            @(negedge clk);
            chk($sformatf("rnd%0d_p1_x%0d", i, a), d1, model_rd(a));
            chk($sformatf("rnd%0d_p2_x%0d", i, b), d2, model_rd(b));
            edge_update();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_reg_file.md
# rv32_reg_file

Integer register file for the pipelined RV32I core, instantiated inside the instruction-decode stage. Provides two combinational read ports addressed by the decoded rs1/rs2 fields and one synchronous write port driven by the write-back stage. Register x0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; register count = 2**ADDR_WIDTH (32)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  reset, synchronous, active-low
- reg1_addr_i  input  ADDR_WIDTH  read port 1 address (rs1)
- reg2_addr_i  input  ADDR_WIDTH  read port 2 address (rs2)
- data1_o  output  DATA_WIDTH  read port 1 data
- data2_o  output  DATA_WIDTH  read port 2 data
- writereg_addr_i  input  ADDR_WIDTH  write address (rd from WB)
- data_i  input  DATA_WIDTH  write data
- data_write_i  input  1  write enable

## Operation
- Storage: 32 entries × DATA_WIDTH; entry 0 never written, always reads 0.
- Write: on rising clk with reset_n=1 and data_write_i=1 and writereg_addr_i≠0, entry[writereg_addr_i] ← data_i. Writes to address 0 silently dropped.
- Read: data1_o/data2_o purely combinational from reg1_addr_i/reg2_addr_i; address 0 → 0 regardless of any write.
- Both read ports may address the same register, or the write target, simultaneously; no conflict.
- Reset: while reset_n=0 at a rising edge, all 32 entries cleared to 0; write port ignored in that cycle (reset wins over write).
- No X propagation: every entry has a defined value after the first reset edge.

## Timing
- Write latency: data visible on read ports after the rising edge that captures it (1 cycle), unless bypass is enabled (see Configuration).
- Read latency: 0 cycles (combinational, same cycle as address change).
- Reset value of outputs: after reset edge, data1_o = data2_o = 0 for every address.
- Reset asserted mid-operation: next edge clears all entries, including a write presented that same cycle.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding. When data_write_i=1, writereg_addr_i≠0, and a read address equals writereg_addr_i, that read port outputs data_i combinationally in the same cycle (resolves WB→ID hazard without an extra stall). Suppressed while reset_n=0? No — bypass depends only on write inputs; reset does not gate it.
- RF_BYPASS_EN undefined: read ports return stored contents only; a same-cycle write is visible only from the next cycle.
- Address 0 always reads 0 in both builds.

## Structure
- Shared package (core-wide): XLEN=32, REG_ADDR_W=5, NUM_REGS=32, REG_ZERO=0 constants; reg_addr_t and xlen_t typedefs used by decode and WB stages.
- One natural sub-module: rf_read_port (address → data mux with x0 zeroing and optional bypass compare), instantiated twice. Storage array and write logic stay in the top.

## Test plan
- Reset: hold reset_n=0 one edge, release; read all 32 addresses on both ports → every value 0.
- Write/read: write x5=0xDEADBEEF; next cycle reg1_addr_i=5 → data1_o=0xDEADBEEF; reg2_addr_i=5 simultaneously → data2_o=0xDEADBEEF.
- x0 protection: write x0=0x12345678 with data_write_i=1; read address 0 on both ports same and next cycle → 0.
- Write-enable gating: data_write_i=0, writereg_addr_i=7, data_i=0xFFFFFFFF; next cycle x7 still previous value (0 after reset).
- Same-cycle read/write on x10 (old 0x1, new 0x2): with RF_BYPASS_EN, data1_o=0x2 that cycle; without it, data1_o=0x1 that cycle and 0x2 next cycle.
- Reset vs write: reset_n=0 while writing x3=0xAA; after edge, x3 reads 0; then fill all 31 registers with distinct values, verify each, reset again → all 0.
